writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter LSU_FIFO_DEPTH, default 2, depth of the long-latency result buffer; legal values are powers of two >= 2.
REQ-002 The block SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port alu_valid_i, input, 1, single-cycle result present; always accepted, never stalled.
REQ-005 The block SHALL have ports alu_rd_i (input, 5, destination register) and alu_data_i (input, 32, result).
REQ-006 The block SHALL have ports lsu_valid_i (input, 1) and lsu_ready_o (output, 1), the long-latency result handshake.
REQ-007 The block SHALL have ports lsu_rd_i (input, 5, destination) and lsu_data_i (input, 32, load/multicycle result).
REQ-008 The block SHALL have ports issue_valid_i (input, 1) and issue_rd_i (input, 5), which reserve a destination for a long-latency op.
REQ-009 The block SHALL have ports busy_query_1_i and busy_query_2_i (input, 5 each), plus busy_1_o and busy_2_o (output, 1 each), the scoreboard lookup.
REQ-010 The block SHALL have ports write_register_o (output, 5), write_back_data_o (output, 32) and ctrl_write_back_o (output, 1), the register-file write port.
REQ-011 The block SHALL have port scoreboard_err_o, output, 1, a sticky protocol-error flag.

Function
REQ-012 The block SHALL register the write port outputs; a result selected in cycle N SHALL appear on the write port in cycle N+1 for exactly one cycle.
REQ-013 The block SHALL perform at most one register-file write per cycle, with priority ALU result > LSU buffer head.
REQ-014 The block SHALL accept an LSU result (push to the FIFO) when lsu_valid_i && lsu_ready_o at a clock edge.
REQ-015 lsu_ready_o SHALL equal !reset_i && (fifo count < LSU_FIFO_DEPTH); it SHALL NOT depend on lsu_valid_i.
REQ-016 The block SHALL pop the FIFO head when the FIFO is non-empty and alu_valid_i = 0; a popped result is presented per REQ-012.
REQ-017 The block SHALL NOT bypass the FIFO: a push at edge N allows a pop at edge N+1 at the earliest, putting data on the write port from cycle N+1 onward.
REQ-018 The block SHALL allow push and pop at the same edge; the count SHALL be unchanged and order SHALL be FIFO.
REQ-019 The block SHALL keep the LSU FIFO waiting while alu_valid_i stays high, with no data loss and no reordering.
REQ-020 A result with rd = 0 (either path) SHALL be consumed normally but SHALL drive ctrl_write_back_o = 0.
REQ-021 When ctrl_write_back_o = 0, write_register_o and write_back_data_o SHALL hold their previous values.
REQ-022 The scoreboard SHALL be a 32-bit busy vector; bit 0 SHALL be constant 0.
REQ-023 issue_valid_i with issue_rd_i != 0 SHALL set busy[issue_rd_i] at that edge.
REQ-024 A FIFO pop with rd != 0 SHALL clear busy[rd] at the pop edge.
REQ-025 A simultaneous set and clear of the same bit SHALL leave the bit set.
REQ-026 ALU writes SHALL NOT modify the scoreboard.
REQ-027 busy_1_o and busy_2_o SHALL be combinational reads of busy[query]; a query of 0 SHALL return 0.
REQ-028 scoreboard_err_o SHALL be set by either: an issue to an already-busy rd != 0 (the set is still applied), or a pop with rd != 0 whose busy bit is clear (the write is still performed).
REQ-029 scoreboard_err_o SHALL stay set until reset.

Reset
REQ-030 While reset_i = 1 at an edge, the block SHALL: empty the FIFO, clear the busy vector, clear scoreboard_err_o, and set ctrl_write_back_o = 0, write_register_o = 0 and write_back_data_o = 0.
REQ-031 Reset mid-operation SHALL discard buffered LSU results, with no write port activity on the following cycle.
REQ-032 lsu_ready_o SHALL be 0 during reset and 1 in the first cycle after reset_i falls.

Verification
REQ-033 Scenario: alu_valid_i=1, rd=5, data=0xDEADBEEF at edge N -> cycle N+1 shows ctrl_write_back_o=1, write_register_o=5, write_back_data_o=0xDEADBEEF; cycle N+2 shows ctrl_write_back_o=0.
REQ-034 Scenario: issue rd=7; later LSU push rd=7, data=0x1234 with ALU idle -> busy(7)=1 until the pop edge; write of 7/0x1234 two cycles after the push; busy(7)=0 in the same cycle the write appears; err=0.
REQ-035 Scenario: ALU valid every cycle for 4 cycles while the LSU pushes 3 results -> ready drops after 2 pushes; after ALU goes idle, the LSU writes drain in push order, one per cycle, and no write is lost.
REQ-036 Scenario: ALU rd=0, data=0xFFFFFFFF -> ctrl_write_back_o=0; issue rd=0 -> busy(0)=0 and err stays 0.
REQ-037 Scenario: issue rd=3 twice without a pop -> scoreboard_err_o=1 and stays 1; reset -> scoreboard_err_o=0, busy(3)=0.
REQ-038 Scenario: FIFO holding 2 entries when reset_i is asserted for one cycle -> no write in the following cycles, lsu_ready_o=0 during reset and 1 after.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges single-cycle ALU results and buffered long-latency
// (LSU / multicycle) results onto one registered register-file write port,
// and keeps a busy scoreboard of destinations owned by in-flight long ops.
//
// Handshake: an LSU result transfers on a rising edge where lsu_valid_i and
// lsu_ready_o are both 1. lsu_ready_o depends only on reset_i and the buffer
// fill level, never on lsu_valid_i. The ALU path has no handshake: a result
// is taken every cycle alu_valid_i is 1 and always wins the write port.
module writeback_unit #(
   parameter int LSU_FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   input  logic [4:0]  busy_query_1_i,
   input  logic [4:0]  busy_query_2_i,
   output logic        busy_1_o,
   output logic        busy_2_o,
   output logic [4:0]  write_register_o,
   output logic [31:0] write_back_data_o,
   output logic        ctrl_write_back_o,
   output logic        scoreboard_err_o
);

   localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Long-latency result buffer (circular, power-of-two depth so pointers wrap naturally)
   logic [4:0]       r_fifo_rd   [LSU_FIFO_DEPTH];
   logic [31:0]      r_fifo_data [LSU_FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [31:0]      r_busy;
   logic             r_err;
   logic             r_ctrl;
   logic [4:0]       r_wreg;
   logic [31:0]      r_wdata;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [4:0]       w_head_rd;
   logic [31:0]      w_head_data;
   logic [31:0]      w_set_mask;
   logic [31:0]      w_clr_mask;
   logic [31:0]      w_busy_next;
   logic             w_issue_err;
   logic             w_pop_err;

   assign w_full      = (r_count == CNT_W'(LSU_FIFO_DEPTH));
   assign lsu_ready_o = !reset_i && !w_full;
   assign w_push      = lsu_valid_i && lsu_ready_o;
   // The head only drains in cycles the ALU leaves the write port free; no bypass
   assign w_pop       = (r_count != '0) && !alu_valid_i;
   assign w_head_rd   = r_fifo_rd[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Set wins over clear on the same bit; bit 0 is never busy
   assign w_set_mask  = (issue_valid_i && (issue_rd_i != 5'd0)) ? (32'd1 << issue_rd_i) : 32'd0;
   assign w_clr_mask  = (w_pop && (w_head_rd != 5'd0)) ? (32'd1 << w_head_rd) : 32'd0;
   assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

   // Errors are judged against the busy state before this edge's update
   assign w_issue_err = issue_valid_i && (issue_rd_i != 5'd0) && r_busy[issue_rd_i];
   assign w_pop_err   = w_pop && (w_head_rd != 5'd0) && !r_busy[w_head_rd];

   assign busy_1_o          = r_busy[busy_query_1_i];
   assign busy_2_o          = r_busy[busy_query_2_i];
   assign write_register_o  = r_wreg;
   assign write_back_data_o = r_wdata;
   assign ctrl_write_back_o = r_ctrl;
   assign scoreboard_err_o  = r_err;

   // Buffer storage: written on accepted LSU results, contents need no reset
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= lsu_rd_i;
         r_fifo_data[r_wr_ptr] <= lsu_data_i;
      end
   end

   // Buffer pointers and fill count
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Scoreboard busy vector and sticky protocol-error flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         if (w_issue_err || w_pop_err) r_err <= 1'b1;
      end
   end

   // Registered write port: ALU first, then buffer head; rd 0 consumes without writing
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ctrl  <= 1'b0;
         r_wreg  <= 5'd0;
         r_wdata <= 32'd0;
      end else if (alu_valid_i) begin
         r_ctrl <= (alu_rd_i != 5'd0);
         if (alu_rd_i != 5'd0) begin
            r_wreg  <= alu_rd_i;
            r_wdata <= alu_data_i;
         end
      end else if (w_pop) begin
         r_ctrl <= (w_head_rd != 5'd0);
         if (w_head_rd != 5'd0) begin
            r_wreg  <= w_head_rd;
            r_wdata <= w_head_data;
         end
      end else begin
         r_ctrl <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, every
// cycle compared against a queue-based behavioural model of the writeback rules.
module tb_writeback_unit;

   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // ---------------- clock / reset block ----------------
   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  q1;
   logic [4:0]  q2;
   logic        busy_1;
   logic        busy_2;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic        wctrl;
   logic        err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   writeback_unit #(.LSU_FIFO_DEPTH(DEPTH)) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .alu_valid_i       (alu_valid),
      .alu_rd_i          (alu_rd),
      .alu_data_i        (alu_data),
      .lsu_valid_i       (lsu_valid),
      .lsu_ready_o       (lsu_ready),
      .lsu_rd_i          (lsu_rd),
      .lsu_data_i        (lsu_data),
      .issue_valid_i     (issue_valid),
      .issue_rd_i        (issue_rd),
      .busy_query_1_i    (q1),
      .busy_query_2_i    (q2),
      .busy_1_o          (busy_1),
      .busy_2_o          (busy_2),
      .write_register_o  (wreg),
      .write_back_data_o (wdata),
      .ctrl_write_back_o (wctrl),
      .scoreboard_err_o  (err)
   );

   // ---------------- scoreboard / reference model ----------------
   int          n_total = 0;
   int          n_bad   = 0;
   ent_t        m_fifo[$];
   bit          m_busy[32];
   bit          m_err;
   bit          m_ctrl;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   bit          m_pushed;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the writeback rules, applied to the current inputs
   function automatic void model_edge();
      int   n;
      bit   do_pop;
      bit   do_push;
      bit   issue_hit;
      ent_t head;
      if (reset) begin
         m_fifo.delete();
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_err    = 1'b0;
         m_ctrl   = 1'b0;
         m_reg    = 5'd0;
         m_data   = 32'd0;
         m_pushed = 1'b0;
         return;
      end
      n         = m_fifo.size();
      do_pop    = (n > 0) && !alu_valid;
      do_push   = lsu_valid && (n < DEPTH);
      issue_hit = issue_valid && (issue_rd != 5'd0);
      if (issue_hit && m_busy[issue_rd]) m_err = 1'b1;
      m_ctrl = 1'b0;
      if (alu_valid) begin
         if (alu_rd != 5'd0) begin
            m_ctrl = 1'b1;
            m_reg  = alu_rd;
            m_data = alu_data;
         end
      end else if (do_pop) begin
         head = m_fifo.pop_front();
         if (head.rd != 5'd0) begin
            m_ctrl = 1'b1;
            m_reg  = head.rd;
            m_data = head.data;
            if (!m_busy[head.rd]) m_err = 1'b1;
            m_busy[head.rd] = 1'b0;
         end
      end
      if (issue_hit) m_busy[issue_rd] = 1'b1;
      if (do_push) m_fifo.push_back('{rd: lsu_rd, data: lsu_data});
      m_pushed = do_push;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      alu_valid   = 1'b0;
      alu_rd      = 5'd0;
      alu_data    = 32'd0;
      lsu_valid   = 1'b0;
      lsu_rd      = 5'd0;
      lsu_data    = 32'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
   endtask

   // Inputs are set at the falling edge; combinational outputs are checked
   // before the rising edge, registered outputs 1 time unit after it.
   task automatic step();
      #1;
      check("ready", {31'd0, lsu_ready}, {31'd0, (!reset && (m_fifo.size() < DEPTH))});
      check("busy1", {31'd0, busy_1}, {31'd0, m_busy[q1]});
      check("busy2", {31'd0, busy_2}, {31'd0, m_busy[q2]});
      @(posedge clk);
      model_edge();
      #1;
      check("wctrl", {31'd0, wctrl}, {31'd0, m_ctrl});
      check("wreg",  {27'd0, wreg},  {27'd0, m_reg});
      check("wdata", wdata, m_data);
      check("err",   {31'd0, err},   {31'd0, m_err});
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pushed;
      int cyc;
      int got_cyc[$];
      idle_inputs();
      q1    = 5'd0;
      q2    = 5'd0;
      reset = 1'b1;
      model_edge();
      repeat (2) @(posedge clk);
      @(negedge clk);
      step();
      check("rst_ctrl", {31'd0, wctrl}, 32'd0);
      check("rst_wreg", {27'd0, wreg}, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_ready", {31'd0, lsu_ready}, 32'd0);
      reset = 1'b0;
      #1 check("ready_after_rst", {31'd0, lsu_ready}, 32'd1);
      step();

      // Single ALU write: one cycle on the port, then quiet
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      check("alu_ctrl", {31'd0, wctrl}, 32'd1);
      check("alu_wreg", {27'd0, wreg}, 32'd5);
      check("alu_wdata", wdata, 32'hDEADBEEF);
      idle_inputs();
      step();
      check("alu_ctrl_off", {31'd0, wctrl}, 32'd0);
      check("alu_hold_data", wdata, 32'hDEADBEEF);

      // Issue rd 7, LSU returns it; busy cleared as the write appears
      q1 = 5'd7;
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      idle_inputs();
      check("lsu_busy_set", {31'd0, busy_1}, 32'd1);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
      step();
      idle_inputs();
      check("lsu_no_bypass", {31'd0, wctrl}, 32'd0);
      check("lsu_busy_held", {31'd0, busy_1}, 32'd1);
      step();
      check("lsu_ctrl", {31'd0, wctrl}, 32'd1);
      check("lsu_wreg", {27'd0, wreg}, 32'd7);
      check("lsu_wdata", wdata, 32'h1234);
      check("lsu_busy_clr", {31'd0, busy_1}, 32'd0);
      check("lsu_err", {31'd0, err}, 32'd0);

      // ALU busy 4 cycles while LSU offers 3 results; drain in order afterwards
      for (int r = 10; r < 13; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r);
         step();
      end
      idle_inputs();
      exp_q.delete();
      pushed = 0;
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(20 + c); alu_data = $urandom;
         lsu_valid = (pushed < 3);
         lsu_rd    = 5'(10 + pushed);
         lsu_data  = 32'hA0000001 + 32'(pushed);
         if (c == 2) check("ready_full", {31'd0, lsu_ready}, 32'd0);
         step();
         if (m_pushed) begin
            exp_q.push_back(32'hA0000001 + 32'(pushed));
            pushed++;
         end
      end
      alu_valid = 1'b0;
      got_cyc.delete();
      cyc = 0;
      for (int c = 0; c < 8; c++) begin
         lsu_valid = (pushed < 3);
         lsu_rd    = 5'(10 + pushed);
         lsu_data  = 32'hA0000001 + 32'(pushed);
         step();
         cyc++;
         if (m_pushed) begin
            exp_q.push_back(32'hA0000001 + 32'(pushed));
            pushed++;
         end
         if (wctrl && (wreg >= 5'd10) && (wreg <= 5'd12)) begin
            got_cyc.push_back(cyc);
            if (exp_q.size() > 0) check("drain_data", wdata, exp_q.pop_front());
            else check("drain_extra", wdata, 32'hFFFF_FFFF);
         end
      end
      idle_inputs();
      check("drain_count", got_cyc.size(), 32'd3);
      for (int i = 1; i < got_cyc.size(); i++)
         check("drain_b2b", got_cyc[i], got_cyc[i-1] + 1);

      // rd 0 results are consumed silently; issue to rd 0 is ignored
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      step();
      check("rd0_ctrl", {31'd0, wctrl}, 32'd0);
      idle_inputs();
      q1 = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd0;
      step();
      idle_inputs();
      check("rd0_busy", {31'd0, busy_1}, 32'd0);
      check("rd0_err", {31'd0, err}, 32'd0);

      // Double issue raises a sticky error, cleared only by reset
      q1 = 5'd3;
      issue_valid = 1'b1; issue_rd = 5'd3;
      step();
      step();
      idle_inputs();
      check("dbl_err", {31'd0, err}, 32'd1);
      step();
      check("dbl_err_sticky", {31'd0, err}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("dbl_err_rst", {31'd0, err}, 32'd0);
      check("dbl_busy_rst", {31'd0, busy_1}, 32'd0);

      // Reset with two buffered results discards them
      for (int r = 4; r < 6; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r);
         alu_valid = 1'b1; alu_rd = 5'(r + 16); alu_data = $urandom;
         lsu_valid = 1'b1; lsu_rd = 5'(r); lsu_data = 32'hB000_0000 + 32'(r);
         step();
      end
      idle_inputs();
      check("rst_fill", m_fifo.size(), 32'd2);
      reset = 1'b1;
      #1 check("rst_ready_low", {31'd0, lsu_ready}, 32'd0);
      step();
      reset = 1'b0;
      #1 check("rst_ready_high", {31'd0, lsu_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_no_write", {31'd0, wctrl}, 32'd0);
      end

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         alu_valid   = ($urandom_range(0, 2) == 0);
         alu_rd      = 5'($urandom_range(0, 31));
         alu_data    = $urandom;
         lsu_valid   = ($urandom_range(0, 1) == 0);
         lsu_rd      = 5'($urandom_range(0, 7));
         lsu_data    = $urandom;
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_rd    = 5'($urandom_range(0, 7));
         q1          = 5'($urandom_range(0, 7));
         q2          = 5'($urandom_range(0, 31));
         step();
      end
      reset = 1'b0;
      idle_inputs();
      step();

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Watchdog: the bench must always end on its own
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
